friscv_uart_rx: RTL and testbench

FRISCV_UART_RX -- requirements
Module: friscv_uart_rx

---
 rtl/friscv_uart_pkg.sv | 29 ++
 rtl/friscv_rx_fifo.sv | 57 +++++
 rtl/friscv_uart_rx.sv | 205 ++++++++++++++++++++
 tb/tb_friscv_uart_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_uart_pkg.sv
// rtl/friscv_uart_pkg.sv - receiver state encoding, frame constants and oversample ratio
// UART_RX_PARITY_EN adds the PARITY state to the enum.
package friscv_uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_W   = $clog2(OVERSAMPLE);
  localparam int DATA_BITS  = 8;
  localparam int BIT_IDX_W  = $clog2(DATA_BITS);

  localparam logic [SAMPLE_W-1:0]  START_SAMPLE = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0]  LAST_SAMPLE  = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT     = BIT_IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/friscv_rx_fifo.sv
// rtl/friscv_rx_fifo.sv - first-word fall-through receive FIFO with occupancy count
// DEPTH must be a power of two so the pointers wrap naturally.
module friscv_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [7:0]               wr_dat_i,
  input  logic                     rd_i,
  output logic [7:0]               rd_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_ok, rd_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign cnt_o   = cnt_q;
  // Head is forced to zero when empty so the output has a defined reset value.
  assign rd_dat_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ok    = rd_i && !empty_o;
    wr_ok    = wr_i && (!full_o || rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_dat_i;
    end
  end

endmodule

// File: rtl/friscv_uart_rx.sv
// rtl/friscv_uart_rx.sv - 16x oversampling 8N1 UART receiver with FIFO and sticky error flags
// UART_RX_PARITY_EN enables an even-parity bit between data and stop.
module friscv_uart_rx
  import friscv_uart_pkg::*;
#(
  parameter int DIVISOR    = 54,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rxd_i,
  input  logic                          rd_i,
  input  logic                          clr_i,
  output logic [7:0]                    dat_o,
  output logic                          rdy_o,
  output logic [$clog2(FIFO_DEPTH):0]   cnt_o,
  output logic                          ferr_o,
  output logic                          ovr_o,
  output logic                          perr_o
);

  localparam int PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic                 rxd_meta_q, rxd_meta_d;
  logic                 rxd_sync_q, rxd_sync_d;
  logic                 rxd_prev_q, rxd_prev_d;
  logic [PW-1:0]        presc_q, presc_d;
  rx_state_e            state_q, state_d;
  logic [SAMPLE_W-1:0]  sample_q, sample_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 brk_q, brk_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick, line, fall;
  logic                 fifo_wr, fifo_full, fifo_empty;
  logic                 ferr_set, ovr_set;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 perr_set;
`endif

  assign line = rxd_sync_q;
  assign fall = rxd_prev_q && !rxd_sync_q;
  assign tick = (presc_q == PW'(DIVISOR - 1));

  always_comb begin
    rxd_meta_d = rxd_i;
    rxd_sync_d = rxd_meta_q;
    rxd_prev_d = rxd_sync_q;
    presc_d    = tick ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    brk_d    = brk_q;
    fifo_wr  = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d  = ST_START;
          sample_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sample_q == START_SAMPLE) begin
            if (line) begin
              state_d = ST_IDLE;
            end else begin
              state_d  = ST_DATA;
              sample_d = '0;
              bit_d    = '0;
            end
          end else begin
            sample_d = sample_q + SAMPLE_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          sample_d = sample_q + SAMPLE_W'(1);
          if (sample_q == LAST_SAMPLE) begin
            shift_d = {line, shift_q[7:1]};
            bit_d   = bit_q + BIT_IDX_W'(1);
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          sample_d = sample_q + SAMPLE_W'(1);
          if (sample_q == LAST_SAMPLE) begin
            perr_set = (even_parity(shift_q) != line);
            state_d  = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        // After a framing error, hold here until the break releases the line.
        if (brk_q) begin
          if (line) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          sample_d = sample_q + SAMPLE_W'(1);
          if (sample_q == LAST_SAMPLE) begin
            if (line) begin
              fifo_wr = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_set = 1'b1;
              brk_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A read in the same cycle as a full-FIFO write frees a slot, so only a lone write overruns.
  always_comb begin
    ovr_set = fifo_wr && fifo_full && !rd_i;
    ferr_d  = ferr_set || (ferr_q && !clr_i);
    ovr_d   = ovr_set  || (ovr_q  && !clr_i);
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_set || (perr_q && !clr_i);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      presc_q    <= '0;
      state_q    <= ST_IDLE;
      sample_q   <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
      rxd_prev_q <= rxd_prev_d;
      presc_q    <= presc_d;
      state_q    <= state_d;
      sample_q   <= sample_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      brk_q      <= brk_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  friscv_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (fifo_wr),
    .wr_dat_i (shift_q),
    .rd_i     (rd_i),
    .rd_dat_o (dat_o),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .cnt_o    (cnt_o)
  );

  assign rdy_o  = !fifo_empty;
  assign ferr_o = ferr_q;
  assign ovr_o  = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_friscv_uart_rx.sv
// tb/tb_friscv_uart_rx.sv - randomized and directed bench with a frame-level timing model
`timescale 1ns/1ps
module tb_friscv_uart_rx;

  localparam int DIV   = 4;
  localparam int DEPTH = 16;
  localparam int BITC  = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Ticks from the first counted tick to the stop sample: half start bit, data, [parity], stop.
  localparam int FRAME_TICKS = PAR_EN ? 8 + 16 * 10 : 8 + 16 * 9;
  localparam int PAR_TICKS   = 8 + 16 * 9;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       rxd_i = 1'b1;
  logic       rd_i = 1'b0;
  logic       clr_i = 1'b0;
  logic [7:0] dat_o;
  logic       rdy_o;
  logic [4:0] cnt_o;
  logic       ferr_o, ovr_o, perr_o;

  friscv_uart_rx #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .rxd_i  (rxd_i),
    .rd_i   (rd_i),
    .clr_i  (clr_i),
    .dat_o  (dat_o),
    .rdy_o  (rdy_o),
    .cnt_o  (cnt_o),
    .ferr_o (ferr_o),
    .ovr_o  (ovr_o),
    .perr_o (perr_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int kind; logic [7:0] b; } ev_t;  // kind: 0 write, 1 ferr, 2 perr
  ev_t        evq[$];
  logic [7:0] mq[$];
  logic       m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
  bit         fs, os, ps, chk_en = 1'b0, rand_done = 1'b0;
  int         cyc = 0, r_cyc = 0, checks = 0, errors = 0;
  logic [7:0] rb, exp_dat;
  ev_t        ev;

  // Reference model: FIFO as a queue, flags as sticky bits, frame outcomes scheduled by send().
  always @(posedge clk) begin
    cyc++;
    if (rst_i) begin
      mq.delete();
      evq.delete();
      m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      r_cyc  = cyc;
      chk_en = 1'b1;
    end else begin
      fs = 1'b0; os = 1'b0; ps = 1'b0;
      if (rd_i && mq.size() > 0) void'(mq.pop_front());
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev = evq.pop_front();
        if (ev.kind == 0) begin
          if (mq.size() < DEPTH) mq.push_back(ev.b);
          else os = 1'b1;
        end else if (ev.kind == 1) fs = 1'b1;
        else ps = 1'b1;
      end
      m_ferr = fs || (m_ferr && !clr_i);
      m_ovr  = os || (m_ovr  && !clr_i);
      m_perr = ps || (m_perr && !clr_i);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_dat = (mq.size() > 0) ? mq[0] : 8'h00;
      checks++;
      if (dat_o !== exp_dat || rdy_o !== (mq.size() > 0) || int'(cnt_o) != mq.size() ||
          ferr_o !== m_ferr || ovr_o !== m_ovr || perr_o !== m_perr) begin
        errors++;
        if (errors <= 20)
          $display("FAIL cycle %0d: dat %h/%h rdy %b/%b cnt %0d/%0d ferr %b/%b ovr %b/%b perr %b/%b (got/expected)",
                   cyc, dat_o, exp_dat, rdy_o, mq.size() > 0, cnt_o, mq.size(),
                   ferr_o, m_ferr, ovr_o, m_ovr, perr_o, m_perr);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    rd_i = 1'b1; step(1); rd_i = 1'b0;
  endtask

  task automatic clr1();
    clr_i = 1'b1; step(1); clr_i = 1'b0;
  endtask

  // The line change lands two flops later; the first counted tick follows the START entry.
  task automatic send(input logic [7:0] b, input int stop_low = 0, input int par_flip = 0,
                      input int abort_bit = -1);
    int k1;
    logic pbit;
    k1 = cyc + 3;
    while (((k1 - r_cyc) % DIV) != DIV - 1) k1++;
    pbit = (^b) ^ (par_flip != 0);
    if (PAR_EN && par_flip != 0) evq.push_back('{k1 + (PAR_TICKS - 1) * DIV + 1, 2, b});
    evq.push_back('{k1 + (FRAME_TICKS - 1) * DIV + 1, (stop_low > 0) ? 1 : 0, b});
    rxd_i = 1'b0; step(BITC);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      if (i == abort_bit) begin
        step(BITC / 2);
        return;
      end
      step(BITC);
    end
    if (PAR_EN) begin
      rxd_i = pbit; step(BITC);
    end
    if (stop_low > 0) begin
      rxd_i = 1'b0; step(stop_low);
    end
    rxd_i = 1'b1; step(BITC);
  endtask

  initial begin
    step(3);
    rst_i = 1'b0;
    chk("reset cnt", int'(cnt_o), 0);
    chk("reset rdy", int'(rdy_o), 0);
    chk("reset flags", int'({ferr_o, ovr_o, perr_o}), 0);
    step(10);

    send(8'hA5);
    chk("a5 dat", int'(dat_o), 'hA5);
    chk("a5 rdy/cnt", int'({rdy_o, cnt_o}), 'h21);
    chk("a5 flags", int'({ferr_o, ovr_o, perr_o}), 0);
    pop1();
    chk("a5 drained", int'(cnt_o), 0);

    rxd_i = 1'b0; step(5 * DIV); rxd_i = 1'b1; step(300);
    chk("glitch cnt", int'(cnt_o), 0);
    chk("glitch flags", int'({ferr_o, ovr_o, perr_o}), 0);

    send(8'h3C, 40 * DIV);
    chk("break ferr", int'(ferr_o), 1);
    chk("break cnt", int'(cnt_o), 0);
    step(50);
    send(8'h11);
    chk("after break dat", int'(dat_o), 'h11);
    chk("after break cnt", int'(cnt_o), 1);
    pop1();
    clr1();
    chk("ferr cleared", int'(ferr_o), 0);

    for (int i = 0; i < 17; i++) send(8'(i));
    chk("ovr cnt", int'(cnt_o), 16);
    chk("ovr flag", int'(ovr_o), 1);
    chk("ovr head", int'(dat_o), 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain order", int'(dat_o), i);
      pop1();
    end
    chk("drained cnt", int'({rdy_o, cnt_o}), 0);
    pop1();
    chk("empty read ignored", int'(cnt_o), 0);
    clr1();
    chk("ovr cleared", int'(ovr_o), 0);

    send(8'h42);
    send(8'h55, 0, 0, 3);
    rst_i = 1'b1; rxd_i = 1'b1; step(1);
    chk("midframe rst dat", int'(dat_o), 0);
    chk("midframe rst rdy/cnt", int'({rdy_o, cnt_o}), 0);
    chk("midframe rst flags", int'({ferr_o, ovr_o, perr_o}), 0);
    step(4); rst_i = 1'b0; step(20);
    send(8'h66);
    chk("after rst dat", int'(dat_o), 'h66);
    chk("after rst cnt", int'(cnt_o), 1);
    pop1();

    if (PAR_EN) begin
      send(8'h07, 0, 1);
      chk("bad parity perr", int'(perr_o), 1);
      chk("bad parity dat", int'(dat_o), 'h07);
      pop1(); clr1();
      send(8'h07);
      chk("good parity perr", int'(perr_o), 0);
      chk("good parity dat", int'(dat_o), 'h07);
      pop1();
    end

    fork
      begin
        for (int n = 0; n < 30; n++) begin
          rb = 8'($urandom);
          step($urandom_range(0, 90));
          if ($urandom_range(0, 9) == 0) send(rb, $urandom_range(70, 150), $urandom_range(0, 1));
          else send(rb, 0, ($urandom_range(0, 5) == 0) ? 1 : 0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rd_i  = ($urandom_range(0, 15) == 0);
          clr_i = ($urandom_range(0, 99) == 0);
          step(1);
        end
        rd_i = 1'b0; clr_i = 1'b0;
      end
    join

    for (int i = 0; i < 20; i++) pop1();
    chk("final drain", int'(cnt_o), 0);
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
